fifo_rr_ctrl: RTL

FIFO_RR_CTRL -- requirements
Module: fifo_rr_ctrl

---
 rtl/fifo_pkg.sv | 15 +
 rtl/rr_arb2.sv | 30 +++
 rtl/fifo_rr_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control blocks: status codes and the default pointer width.
package fifo_pkg;

  localparam int FIFO_AW = 3;

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_READ     = 3'b001,
    ST_WRITE    = 3'b010,
    ST_RD_ERROR = 3'b011,
    ST_WR_ERROR = 3'b100,
    ST_NO_OP    = 3'b101
  } fifo_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational and is only produced
// while en is high; the last-grant history moves only on an issued grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // 1 means requester 1 won the most recent issued grant
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (en && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/fifo_rr_ctrl.sv
// Two-writer / one-reader FIFO controller with read priority and round-robin write grant.
// Optional FIFO_RR_CTRL_ALMOST_EN adds registered almost_full / almost_empty flags.
module fifo_rr_ctrl
  import fifo_pkg::*;
#(
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_req0,
  input  logic          wr_req1,
  input  logic          rd_en,
  output logic [1:0]    wr_gnt,
  output logic          we,
  output logic          re,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic [2:0]    state,
  output logic [AW:0]   data_count,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err
`ifdef FIFO_RR_CTRL_ALMOST_EN
  ,
  output logic          almost_full,
  output logic          almost_empty
`endif
);

  localparam logic [AW:0]   DEPTH_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  fifo_state_t state_q;
  logic        cnt_zero, cnt_full, wr_any;
  logic        rd_ok, rd_bad, wr_ok, wr_bad;
  logic [AW:0] count_nxt;

  assign cnt_zero = (data_count == '0);
  assign cnt_full = (data_count == DEPTH_CNT);
  assign wr_any   = wr_req0 | wr_req1;

  // Reads always win; a read against an empty FIFO still blocks any write that cycle
  assign rd_ok  = reset_n & rd_en & ~cnt_zero;
  assign rd_bad = rd_en & cnt_zero;
  assign wr_ok  = reset_n & ~rd_en & wr_any & ~cnt_full;
  assign wr_bad = ~rd_en & wr_any & cnt_full;

  assign re = rd_ok;
  assign we = wr_ok;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({wr_req1, wr_req0}),
    .en      (wr_ok),
    .gnt     (wr_gnt)
  );

  always_comb begin
    count_nxt = data_count;
    if (rd_ok)      count_nxt = data_count - CNT_ONE;
    else if (wr_ok) count_nxt = data_count + CNT_ONE;
  end

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      data_count   <= '0;
      waddr        <= '0;
      raddr        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_err       <= 1'b0;
`ifdef FIFO_RR_CTRL_ALMOST_EN
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
`endif
    end else begin
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
      data_count <= count_nxt;
      full       <= (count_nxt == DEPTH_CNT);
      empty      <= (count_nxt == '0);
`ifdef FIFO_RR_CTRL_ALMOST_EN
      almost_full  <= (count_nxt >= (DEPTH_CNT - CNT_ONE));
      almost_empty <= (count_nxt <= CNT_ONE);
`endif
      if (rd_ok) begin
        state_q <= ST_READ;
        rd_ack  <= 1'b1;
        raddr   <= raddr + PTR_ONE;
      end else if (rd_bad) begin
        state_q <= ST_RD_ERROR;
        rd_err  <= 1'b1;
      end else if (wr_ok) begin
        state_q <= ST_WRITE;
        wr_ack  <= 1'b1;
        waddr   <= waddr + PTR_ONE;
      end else if (wr_bad) begin
        state_q <= ST_WR_ERROR;
        wr_err  <= 1'b1;
      end else begin
        state_q <= ST_NO_OP;
      end
    end
  end

endmodule
